// File: rtl/c64_debug_pkg.sv
// Shared C64 debug-port definitions: arbiter states, UART monitor opcodes and bus widths.
package c64_debug_pkg;

    localparam int unsigned DEBUG_ADDR_W = 16;
    localparam int unsigned DEBUG_DATA_W = 8;

    localparam logic [7:0] DEBUG_READ_OP   = 8'd1;
    localparam logic [7:0] DEBUG_WRITE_OP  = 8'd2;
    localparam logic [7:0] DEBUG_WRITE_PS2 = 8'd3;

    localparam logic [7:0] DEBUG_WRITE_ACK    = 8'h06;
    localparam logic [7:0] DEBUG_TIMEOUT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ACCESS,
        DONE
    } arb_state_t;

    // Writes complete with a zero data byte so requesters never see stale read data.
    function automatic logic [DEBUG_DATA_W-1:0] completion_data(
        input logic                    we,
        input logic [DEBUG_DATA_W-1:0] rdata
    );
        return we ? '0 : rdata;
    endfunction

endpackage

// File: rtl/c64_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module c64_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   grant,
    output logic            valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!valid && req_valid[j] && (((32'(ptr) + i) % NREQ) == j)) begin
                    grant = PW'(j);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/c64_debug_arbiter.sv
// Round-robin arbiter sharing the C64 bus debug port via the core's bus-hold handshake.
// Optional HOLD timeout enabled by defining C64_DEBUG_ARB_TIMEOUT_EN.
module c64_debug_arbiter
    import c64_debug_pkg::*;
#(
    parameter int unsigned NREQ          = 2,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_we,
    input  logic [DEBUG_ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DEBUG_DATA_W*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]                req_ack,
    output logic [DEBUG_DATA_W-1:0]        req_rdata,
    output logic                           req_error,
    output logic                           bus_hold,
    input  logic                           bus_ready,
    output logic [DEBUG_ADDR_W-1:0]        bus_addr,
    output logic [DEBUG_DATA_W-1:0]        bus_wdata,
    output logic                           bus_we,
    input  logic [DEBUG_DATA_W-1:0]        bus_rdata,
    output logic                           busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    if (NREQ < 1 || NREQ > 4 || ACCESS_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT > 1048575) begin : g_param_check
        $error("c64_debug_arbiter: parameter out of range");
    end

    arb_state_t state, state_n;

    logic [PW-1:0]           ptr, grant_q, pick_grant;
    logic                    pick_valid, after_done, we_q, sel_we;
    logic [NREQ-1:0]         pick_req;
    logic [DEBUG_ADDR_W-1:0] addr_q, sel_addr, bus_addr_q;
    logic [DEBUG_DATA_W-1:0] wdata_q, sel_wdata, bus_wdata_q, rdata_q;
    logic [CW-1:0]           cnt;

`ifdef C64_DEBUG_ARB_TIMEOUT_EN
    logic [19:0] tcnt;
    logic        error_q;
    logic        timeout_hit;
    assign timeout_hit = (tcnt == 20'(TIMEOUT - 1));
`endif

    // The requester just acked may still show req_valid for one cycle; keep it out of that pick.
    always_comb begin
        pick_req = req_valid;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (after_done && grant_q == PW'(i)) pick_req[i] = 1'b0;
        end
    end

    c64_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_valid (pick_req),
        .ptr       (ptr),
        .grant     (pick_grant),
        .valid     (pick_valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_grant == PW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*DEBUG_ADDR_W +: DEBUG_ADDR_W];
                sel_wdata = req_wdata[i*DEBUG_DATA_W +: DEBUG_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (pick_valid) state_n = HOLD;
            HOLD: begin
                if (bus_ready) state_n = ACCESS;
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
                else if (timeout_hit) state_n = DONE;
`endif
            end
            ACCESS: begin
                if (!bus_ready)     state_n = HOLD;
                else if (cnt == '0) state_n = DONE;
            end
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        bus_hold = (state == HOLD) || (state == ACCESS);
        bus_we   = (state == ACCESS) && we_q && bus_ready;
        req_ack  = '0;
        if (state == DONE) begin
            for (int unsigned i = 0; i < NREQ; i++) req_ack[i] = (grant_q == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            grant_q     <= '0;
            after_done  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            cnt         <= '0;
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
            tcnt        <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            after_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_grant;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end
                end
                HOLD: begin
                    if (bus_ready) begin
                        cnt         <= CW'(ACCESS_CYCLES - 1);
                        bus_addr_q  <= addr_q;
                        bus_wdata_q <= wdata_q;
                    end
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rdata_q <= DEBUG_TIMEOUT_DATA;
                        error_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                ACCESS: begin
                    if (!bus_ready) begin
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
                        tcnt <= '0;
`endif
                    end else if (cnt == '0) begin
                        rdata_q <= completion_data(we_q, bus_rdata);
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: ptr <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign req_rdata = rdata_q;
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
    assign req_error = error_q;
`else
    assign req_error = 1'b0;
`endif

endmodule

// File: tb/tb_c64_debug_arbiter.sv
// Scoreboard bench for c64_debug_arbiter: expected acks queued at request time, checked by an ack monitor.
module tb_c64_debug_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AC   = 2;
    localparam int unsigned TMO  = 100;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_we, req_ack;
    logic [16*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]    req_wdata;
    logic [7:0]           req_rdata, bus_wdata, bus_rdata;
    logic                 req_error, bus_hold, bus_ready, bus_we, busy;
    logic [15:0]          bus_addr;

    typedef struct {
        int unsigned idx;
        logic [7:0]  rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_total = 0;
    int   last_ack_cyc = 0;
    int   cyc = 0;
    bit   auto_drop = 1'b1;
    logic [NREQ-1:0] pending_drop = '0;
    exp_t mon_e;
    logic [NREQ-1:0] mon_onehot;

    c64_debug_arbiter #(.NREQ(NREQ), .ACCESS_CYCLES(AC), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .req_error (req_error),
        .bus_hold  (bus_hold),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Requester model: drop req_valid in the cycle after its ack.
    always @(posedge clk) begin
        #2;
        req_valid    = req_valid & ~pending_drop;
        pending_drop = '0;
    end

    always @(negedge clk) begin
        if (!reset && req_ack !== '0) begin
            ack_total++;
            last_ack_cyc = cyc;
            checks++;
            if ($countones(req_ack) != 1) begin
                errors++;
                $display("FAIL ack_onehot: req_ack=%b, required exactly one bit", req_ack);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: req_ack=%b with no transaction outstanding", req_ack);
            end else begin
                mon_e = sb.pop_front();
                mon_onehot = '0;
                mon_onehot[mon_e.idx] = 1'b1;
                if (req_ack !== mon_onehot || req_rdata !== mon_e.rdata || req_error !== mon_e.err)
                    begin
                    errors++;
                    $display("FAIL ack_data: ack=%b rdata=%h err=%b, required ack=%b rdata=%h err=%b",
                             req_ack, req_rdata, req_error, mon_onehot, mon_e.rdata, mon_e.err);
                end
            end
            if (auto_drop) pending_drop = pending_drop | req_ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic we, input logic [15:0] a, input logic [7:0] d);
        req_we[i]            = we;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*8 +: 8]  = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic push_exp(input int unsigned i, input logic [7:0] r, input logic e);
        exp_t x;
        x.idx   = i;
        x.rdata = r;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic wait_acks(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            if (ack_total >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ack, req_error, bus_hold, bus_we, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b err=%b hold=%b we=%b busy=%b, required all 0",
                     req_ack, req_error, bus_hold, bus_we, busy);
        end
        checks++;
        if ({req_rdata, bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0", req_rdata, bus_addr, bus_wdata);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int c0, base, we_cnt, hold_at;
        bus_ready = 1'b1; bus_rdata = 8'h0E;
        tick();
        c0 = cyc; base = ack_total; we_cnt = 0; hold_at = -1;
        set_req(0, 1'b0, 16'hD020, 8'h00);
        push_exp(0, 8'h0E, 1'b0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus_we) we_cnt++;
            if (bus_hold && hold_at < 0) hold_at = cyc - c0;
        end
        checks++;
        if (hold_at != 1) begin errors++; $display("FAIL read_hold_delay: got %0d, required 1", hold_at); end
        checks++;
        if (ack_total - base != 1) begin errors++; $display("FAIL read_ack_count: got %0d, required 1", ack_total - base); end
        checks++;
        if (last_ack_cyc - c0 != 2 + AC) begin
            errors++; $display("FAIL read_latency: got %0d, required %0d", last_ack_cyc - c0, 2 + AC);
        end
        checks++;
        if (we_cnt != 0) begin errors++; $display("FAIL read_we: bus_we high %0d cycles, required 0", we_cnt); end
        checks++;
        if (bus_addr !== 16'hD020) begin errors++; $display("FAIL read_addr: got %h, required d020", bus_addr); end
        tick();
    endtask

    task automatic test_write_delayed();
        int c0, base, we_cnt, we_bad;
        bus_ready = 1'b0;
        tick();
        c0 = cyc; base = ack_total; we_cnt = 0; we_bad = 0;
        set_req(1, 1'b1, 16'h0400, 8'h41);
        push_exp(1, 8'h00, 1'b0);
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus_we) begin
                we_cnt++;
                if (bus_addr !== 16'h0400 || bus_wdata !== 8'h41) we_bad++;
            end
            if (cyc - c0 == 10) bus_ready = 1'b1;
        end
        checks++;
        if (we_cnt != AC) begin errors++; $display("FAIL write_we_cycles: got %0d, required %0d", we_cnt, AC); end
        checks++;
        if (we_bad != 0) begin errors++; $display("FAIL write_bus_operands: %0d bad cycles, required 0", we_bad); end
        checks++;
        if (ack_total - base != 1) begin errors++; $display("FAIL write_ack_count: got %0d, required 1", ack_total - base); end
        checks++;
        if (last_ack_cyc - c0 != 11 + AC) begin
            errors++; $display("FAIL write_latency: got %0d, required %0d", last_ack_cyc - c0, 11 + AC);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int base;
        bit ok;
        bus_ready = 1'b1; bus_rdata = 8'h5A; auto_drop = 1'b0;
        tick();
        base = ack_total;
        set_req(0, 1'b0, 16'h1000, 8'h00);
        set_req(1, 1'b1, 16'h2000, 8'h77);
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 8'h5A, 1'b0);
            push_exp(1, 8'h00, 1'b0);
        end
        wait_acks(base + 6, 100, ok);
        #1;
        req_valid = '0;
        auto_drop = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: %0d acks, required 6", ack_total - base); end
        repeat (8) tick();
        checks++;
        if (ack_total - base != 6) begin errors++; $display("FAIL rr_ack_count: got %0d, required 6", ack_total - base); end
    endtask

    task automatic test_back_to_back();
        int base, a1, a2;
        bit ok;
        bus_ready = 1'b1; bus_rdata = 8'h33; auto_drop = 1'b0;
        tick();
        base = ack_total;
        set_req(0, 1'b0, 16'h3000, 8'h00);
        for (int k = 0; k < 3; k++) push_exp(0, 8'h33, 1'b0);
        wait_acks(base + 1, 40, ok);
        a1 = last_ack_cyc;
        wait_acks(base + 2, 40, ok);
        a2 = last_ack_cyc;
        checks++;
        if (a2 - a1 != 4 + AC) begin errors++; $display("FAIL b2b_period1: got %0d, required %0d", a2 - a1, 4 + AC); end
        wait_acks(base + 3, 40, ok);
        #1;
        req_valid = '0;
        auto_drop = 1'b1;
        checks++;
        if (!ok || last_ack_cyc - a2 != 4 + AC) begin
            errors++; $display("FAIL b2b_period2: got %0d (done=%0d), required %0d", last_ack_cyc - a2, ok, 4 + AC);
        end
        repeat (4) tick();
    endtask

    task automatic test_ready_drop();
        int c0, base, we_cnt;
        bus_ready = 1'b1;
        tick();
        c0 = cyc; base = ack_total; we_cnt = 0;
        set_req(0, 1'b1, 16'hC000, 8'h99);
        push_exp(0, 8'h00, 1'b0);
        tick();
        tick();
        bus_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_we !== 1'b0 || bus_hold !== 1'b1) begin
            errors++; $display("FAIL drop_we: we=%b hold=%b, required we=0 hold=1", bus_we, bus_hold);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus_we) we_cnt++;
            if (cyc - c0 == 5) bus_ready = 1'b1;
        end
        checks++;
        if (we_cnt != AC) begin errors++; $display("FAIL drop_we_cycles: got %0d, required %0d", we_cnt, AC); end
        checks++;
        if (ack_total - base != 1) begin errors++; $display("FAIL drop_ack_count: got %0d, required 1", ack_total - base); end
        checks++;
        if (last_ack_cyc - c0 != 6 + AC) begin
            errors++; $display("FAIL drop_latency: got %0d, required %0d", last_ack_cyc - c0, 6 + AC);
        end
        tick();
    endtask

    task automatic test_timeout();
        int c0, base, we_cnt;
        bus_ready = 1'b0;
        tick();
        c0 = cyc; base = ack_total; we_cnt = 0;
        set_req(1, 1'b0, 16'h1234, 8'h00);
`ifdef C64_DEBUG_ARB_TIMEOUT_EN
        push_exp(1, 8'hFF, 1'b1);
        for (int n = 0; n < TMO + 20; n++) begin
            @(negedge clk);
            if (bus_we) we_cnt++;
        end
        checks++;
        if (ack_total - base != 1) begin errors++; $display("FAIL tmo_ack_count: got %0d, required 1", ack_total - base); end
        checks++;
        if (last_ack_cyc - c0 != TMO + 1) begin
            errors++; $display("FAIL tmo_latency: got %0d, required %0d", last_ack_cyc - c0, TMO + 1);
        end
        checks++;
        if (we_cnt != 0) begin errors++; $display("FAIL tmo_we: bus_we high %0d cycles, required 0", we_cnt); end
        bus_ready = 1'b1;
        tick();
`else
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if (bus_we) we_cnt++;
        end
        checks++;
        if (ack_total - base != 0) begin errors++; $display("FAIL hold_ack_count: got %0d, required 0", ack_total - base); end
        checks++;
        if (we_cnt != 0 || bus_hold !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL hold_wait: we_cycles=%0d hold=%b busy=%b, required 0/1/1", we_cnt, bus_hold, busy);
        end
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        bus_ready = 1'b1;
        tick();
`endif
    endtask

    task automatic test_reset_mid_access();
        int base;
        bit ok;
        bus_ready = 1'b1; bus_rdata = 8'h11;
        tick();
        base = ack_total;
        set_req(0, 1'b0, 16'h0001, 8'h00);
        push_exp(0, 8'h11, 1'b0);
        wait_acks(base + 1, 20, ok);
        repeat (2) tick();
        base = ack_total;
        set_req(0, 1'b1, 16'h0002, 8'h55);
        tick();
        tick();
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_hold !== 1'b0 || bus_we !== 1'b0 || busy !== 1'b0 || req_ack !== '0) begin
            errors++; $display("FAIL abort_state: hold=%b we=%b busy=%b ack=%b, required all 0",
                               bus_hold, bus_we, busy, req_ack);
        end
        tick();
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (ack_total != base) begin errors++; $display("FAIL abort_ack: got %0d acks, required 0", ack_total - base); end
        set_req(1, 1'b0, 16'h0101, 8'h00);
        set_req(0, 1'b0, 16'h0100, 8'h00);
        push_exp(0, 8'h11, 1'b0);
        push_exp(1, 8'h11, 1'b0);
        wait_acks(base + 2, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL post_reset_acks: got %0d, required 2", ack_total - base); end
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_delayed();
        test_round_robin();
        test_back_to_back();
        test_ready_drop();
        test_timeout();
        test_reset_mid_access();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d transactions never acked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
